// File: rtl/matrix_row_server.sv
// ---------------------------------------------------------------------------
// matrix_row_server
//
// Holds a SIZE x SIZE matrix of 128-bit complex elements ({imag, real}) and
// serves whole rows to a consumer with a fixed one-cycle read latency.
// Rows are loaded one at a time. A per-row valid mask tracks which rows hold
// data, and a load counter of distinct rows decides when the matrix is full.
// With TRI_MASK set, elements above the diagonal are stored as zero, which
// leaves a lower-triangular matrix.
//
// Ports
//   clk_i            clock; all state changes on the rising edge
//   rst_ni           asynchronous active-low reset
//   wr_row_i         row to store, SIZE elements of {imag[127:64], real[63:0]}
//   wr_addr_i        row index to write
//   wr_valid_i       write request
//   wr_ready_o       write accepted when wr_valid_i & wr_ready_o
//   clear_i          invalidates every stored row; data itself is kept
//   rd_addr_i        requested row index
//   rd_addr_valid_i  read request (level, may be held)
//   mat_row_o        returned row, one cycle after the request
//   mat_row_addr_o   index tag of mat_row_o
//   mat_row_valid_o  mat_row_o / mat_row_addr_o valid this cycle
//   loaded_o         all SIZE rows hold valid data
//   busy_o           high while loading or serving
// ---------------------------------------------------------------------------

// Per-element write path. COL is the element's column index. When masking is
// enabled, any column to the right of the target row is replaced by zero.
module matrix_row_server_lane #(
  parameter int SIZE     = 16,
  parameter int AW       = 4,
  parameter int COL      = 0,
  parameter bit TRI_MASK = 1'b1
) (
  input  logic [AW-1:0] row,
  input  logic [127:0]  din,
  output logic [127:0]  dout
);
  localparam logic [AW-1:0] COL_IDX = AW'(COL);

  always_comb begin
    dout = din;
    if (TRI_MASK && (COL_IDX > row)) dout = '0;
  end
endmodule

module matrix_row_server #(
  parameter  int SIZE     = 16,
  parameter  bit TRI_MASK = 1'b1,
  localparam int AW       = $clog2(SIZE),
  localparam int CW       = AW + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [SIZE-1:0][127:0] wr_row_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic                  clear_i,
  input  logic [AW-1:0]         rd_addr_i,
  input  logic                  rd_addr_valid_i,
  output logic [SIZE-1:0][127:0] mat_row_o,
  output logic [AW-1:0]         mat_row_addr_o,
  output logic                  mat_row_valid_o,
  output logic                  loaded_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {EMPTY, LOAD, FULL, SERVE} state_t;

  state_t                 state;
  logic [SIZE-1:0]        row_valid;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_next;
  logic                   wr_fire;
  logic                   new_row;
  logic [SIZE-1:0][127:0] wr_masked;

  // Row storage. It has no reset: contents are undefined after reset, and
  // row_valid is the only thing that says whether a row may be trusted.
  logic [SIZE-1:0][127:0] mem [SIZE];

  // clear_i takes priority over everything, so it also blocks writes.
  assign wr_ready_o = (state != SERVE) && !clear_i;
  assign busy_o     = (state == LOAD) || (state == SERVE);
  assign wr_fire    = wr_valid_i && wr_ready_o;

  // Only the first write to a row counts toward the load. Rewrites of a
  // loaded row just overwrite its data.
  assign new_row  = wr_fire && !row_valid[wr_addr_i];
  assign cnt_next = cnt + CW'(new_row);

  for (genvar j = 0; j < SIZE; j++) begin : g_lane
    matrix_row_server_lane #(
      .SIZE     (SIZE),
      .AW       (AW),
      .COL      (j),
      .TRI_MASK (TRI_MASK)
    ) u_lane (
      .row  (wr_addr_i),
      .din  (wr_row_i[j]),
      .dout (wr_masked[j])
    );
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) mem[wr_addr_i] <= wr_masked;
  end

  // The read samples mem and row_valid before this edge's write lands. A
  // same-row write and read in one cycle therefore returns the old row.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= EMPTY;
      row_valid       <= '0;
      cnt             <= '0;
      loaded_o        <= 1'b0;
      mat_row_valid_o <= 1'b0;
      mat_row_addr_o  <= '0;
      mat_row_o       <= '0;
    end else if (clear_i) begin
      // Row data and the last returned row and tag are kept.
      state           <= EMPTY;
      row_valid       <= '0;
      cnt             <= '0;
      loaded_o        <= 1'b0;
      mat_row_valid_o <= 1'b0;
    end else begin
      if (rd_addr_valid_i) begin
        mat_row_o       <= mem[rd_addr_i];
        mat_row_addr_o  <= rd_addr_i;
        mat_row_valid_o <= row_valid[rd_addr_i];
      end else begin
        mat_row_valid_o <= 1'b0;
      end

      if (wr_fire) begin
        row_valid[wr_addr_i] <= 1'b1;
        cnt                  <= cnt_next;
      end
      loaded_o <= (cnt_next == CW'(SIZE));

      unique case (state)
        EMPTY: if (wr_fire) state <= LOAD;
        LOAD:  if (wr_fire && (cnt_next == CW'(SIZE))) state <= FULL;
        FULL:  if (rd_addr_valid_i) state <= SERVE;
        SERVE: if (!rd_addr_valid_i) state <= FULL;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_row_server.sv
// ---------------------------------------------------------------------------
// tb_matrix_row_server
//
// Directed scenarios followed by randomized traffic. Every cycle's outputs are
// compared against a behavioural model. The model tracks the matrix, the set
// of loaded rows and a "serving" flag. EMPTY, LOAD and FULL are not tracked as
// states; they follow from how many distinct rows are loaded.
// ---------------------------------------------------------------------------
module tb_matrix_row_server;
  localparam int SIZE = 16;
  localparam int AW   = $clog2(SIZE);

  logic                   clk_i = 1'b0;
  logic                   rst_ni = 1'b1;
  logic [SIZE-1:0][127:0] wr_row_i = '0;
  logic [AW-1:0]          wr_addr_i = '0;
  logic                   wr_valid_i = 1'b0;
  logic                   wr_ready_o;
  logic                   clear_i = 1'b0;
  logic [AW-1:0]          rd_addr_i = '0;
  logic                   rd_addr_valid_i = 1'b0;
  logic [SIZE-1:0][127:0] mat_row_o;
  logic [AW-1:0]          mat_row_addr_o;
  logic                   mat_row_valid_o;
  logic                   loaded_o;
  logic                   busy_o;

  always #5 clk_i = ~clk_i;

  matrix_row_server #(.SIZE(SIZE), .TRI_MASK(1'b1)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .wr_row_i        (wr_row_i),
    .wr_addr_i       (wr_addr_i),
    .wr_valid_i      (wr_valid_i),
    .wr_ready_o      (wr_ready_o),
    .clear_i         (clear_i),
    .rd_addr_i       (rd_addr_i),
    .rd_addr_valid_i (rd_addr_valid_i),
    .mat_row_o       (mat_row_o),
    .mat_row_addr_o  (mat_row_addr_o),
    .mat_row_valid_o (mat_row_valid_o),
    .loaded_o        (loaded_o),
    .busy_o          (busy_o)
  );

  // Reference model
  logic [127:0] m_mem [SIZE][SIZE];
  bit           m_valid [SIZE];
  int           m_cnt;
  bit           m_loaded, m_serving, m_ovld;
  int           m_oaddr;
  logic [127:0] m_orow [SIZE];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h exp %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_busy();
    return ((m_cnt > 0) && (m_cnt < SIZE)) || m_serving;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SIZE; i++) begin
      m_valid[i] = 1'b0;
      m_orow[i]  = '0;
    end
    m_cnt = 0; m_loaded = 0; m_serving = 0; m_ovld = 0; m_oaddr = 0;
  endtask

  task automatic model_edge(input bit wv, input int wa, input logic [SIZE-1:0][127:0] wrow,
                            input bit rv, input int ra, input bit clr);
    bit was_full;
    bit accept;
    if (clr) begin
      for (int i = 0; i < SIZE; i++) m_valid[i] = 1'b0;
      m_cnt = 0; m_loaded = 0; m_ovld = 0; m_serving = 0;
      return;
    end
    was_full = (m_cnt == SIZE);
    accept   = wv && !m_serving;
    if (rv) begin
      for (int j = 0; j < SIZE; j++) m_orow[j] = m_mem[ra][j];
      m_oaddr = ra;
      m_ovld  = m_valid[ra];
    end else begin
      m_ovld = 0;
    end
    if (accept) begin
      if (!m_valid[wa]) m_cnt++;
      m_valid[wa] = 1'b1;
      for (int j = 0; j < SIZE; j++) m_mem[wa][j] = (j > wa) ? 128'd0 : wrow[j];
    end
    m_loaded  = (m_cnt == SIZE);
    m_serving = rv && was_full;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_vld"}, mat_row_valid_o, 0);
    chk({tag, "_addr"}, mat_row_addr_o, 0);
    chk({tag, "_loaded"}, loaded_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    for (int j = 0; j < SIZE; j++) chk({tag, "_row"}, mat_row_o[j], 0);
  endtask

  // One clock cycle. Inputs are driven at negedge and the combinational
  // outputs are checked there. An optional async reset pulse can be applied
  // before the rising edge. Registered outputs are checked 1ns after it.
  task automatic step(input bit wv, input int wa, input logic [SIZE-1:0][127:0] wrow,
                      input bit rv, input int ra, input bit clr, input bit rst_pulse);
    @(negedge clk_i);
    wr_valid_i = wv; wr_addr_i = AW'(wa); wr_row_i = wrow;
    rd_addr_valid_i = rv; rd_addr_i = AW'(ra); clear_i = clr;
    #1;
    chk("wr_ready", wr_ready_o, !m_serving && !clr);
    chk("busy_pre", busy_o, m_busy());
    if (rst_pulse) begin
      rst_ni = 1'b0;
      #1;
      chk_zero_outputs("rst_async");
      model_reset();
      #1 rst_ni = 1'b1;
    end
    @(posedge clk_i);
    model_edge(wv, wa, wrow, rv, ra, clr);
    #1;
    chk("row_vld", mat_row_valid_o, m_ovld);
    chk("row_addr", mat_row_addr_o, m_oaddr);
    chk("loaded", loaded_o, m_loaded);
    chk("busy", busy_o, m_busy());
    if (m_ovld)
      for (int j = 0; j < SIZE; j++) chk("row_data", mat_row_o[j], m_orow[j]);
  endtask

  function automatic logic [SIZE-1:0][127:0] rnd_row();
    logic [SIZE-1:0][127:0] r;
    for (int j = 0; j < SIZE; j++) r[j] = {$urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction

  function automatic logic [SIZE-1:0][127:0] pat_row(input int i);
    logic [SIZE-1:0][127:0] r;
    for (int j = 0; j < SIZE; j++) r[j] = {64'(j), 64'(i)};
    return r;
  endfunction

  initial begin
    logic [SIZE-1:0][127:0] zrow;
    zrow = '0;
    #1 rst_ni = 1'b0;
    #20;
    chk_zero_outputs("reset");
    model_reset();
    @(negedge clk_i);
    #1 rst_ni = 1'b1;

    // Row 7 is read before it is written, then written and read on the same
    // edge, which returns the old data. The load then completes with
    // element j = {j, i}.
    step(0, 0, zrow, 1, 7, 0, 0);
    for (int i = 0; i < SIZE; i++)
      step(1, i, pat_row(i), (i == 7) || (i == 8), 7, 0, 0);
    chk("loaded_after_16", loaded_o, 1);

    // Row 3 read: the upper triangle comes back as zero.
    step(0, 0, zrow, 1, 3, 0, 0);
    chk("tri_row3_e4", mat_row_o[4], 0);
    chk("tri_row3_e15", mat_row_o[15], 0);
    chk("tri_row3_e3", mat_row_o[3], {64'd3, 64'd3});

    // Row 5 is held for three cycles while writes are attempted. They must
    // be refused while serving.
    for (int k = 0; k < 3; k++) step(1, 1, rnd_row(), 1, 5, 0, 0);
    step(0, 0, zrow, 0, 0, 0, 0);

    // A clear while row 9 is being served.
    step(0, 0, zrow, 1, 9, 0, 0);
    step(0, 0, zrow, 1, 9, 0, 0);
    step(0, 0, zrow, 1, 9, 1, 0);
    step(0, 0, zrow, 0, 0, 0, 0);

    // Row 2 is rewritten during the load; it counts only once.
    step(1, 2, rnd_row(), 0, 0, 0, 0);
    step(1, 2, rnd_row(), 0, 0, 0, 0);
    step(1, 2, rnd_row(), 1, 2, 0, 0);
    for (int i = 0; i < SIZE; i++)
      if (i != 2) step(1, i, rnd_row(), 0, 0, 0, 0);
    chk("loaded_after_rewrites", loaded_o, 1);

    // Async reset in the middle of a load, then a read of row 0.
    step(0, 0, zrow, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, i, rnd_row(), 0, 0, 0, 0);
    step(0, 0, zrow, 0, 0, 0, 1);
    step(0, 0, zrow, 1, 0, 0, 0);
    chk("post_reset_row0_vld", mat_row_valid_o, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) < 60, $urandom_range(0, SIZE - 1), rnd_row(),
           $urandom_range(0, 99) < 50, $urandom_range(0, SIZE - 1),
           $urandom_range(0, 199) == 0, $urandom_range(0, 399) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
